// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store controller between EX/MEM and the data memory.
// Takes one request through a valid/ready handshake, qualifies it (alignment
// and address range), drives the synchronous-read memory from latched
// registers and holds a registered response until MEM/WB consumes it.
module lsu_mem_stage #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_load,
  input  logic        req_is_store,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_func3,
  input  logic [4:0]  req_rd,
  output logic        mem_en_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_store_data,
  output logic [2:0]  mem_func3,
  input  logic [31:0] mem_load_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic [1:0]  rsp_fault,
  output logic [31:0] rsp_badaddr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_READ   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_func3;
  logic [4:0]  r_rd;
  logic        r_is_load;
  logic        r_is_store;
  logic [1:0]  r_fault;
  logic [31:0] r_rsp_data;
  logic        r_rsp_valid;
  logic        r_mem_we;

  logic        w_accept;
  logic [1:0]  w_fault;
  logic        w_ok_load;

  // Fault bits for a request: bit0 misaligned/illegal, bit1 outside the
  // decoded memory window. Both may be set at once.
  function automatic logic [1:0] calc_fault(input logic [31:0] addr,
                                            input logic [2:0]  f3,
                                            input logic        ld,
                                            input logic        st);
    logic mis;
    logic oor;
    mis = 1'b0;
    case (f3[1:0])
      2'b01:   mis = addr[0];
      2'b10:   mis = (addr[1:0] != 2'b00);
      2'b11:   mis = 1'b1;
      default: mis = 1'b0;
    endcase
    // 110/111 have no RV32I load/store meaning
    if (f3 == 3'b110 || f3 == 3'b111) mis = 1'b1;
    // unsigned variants exist only for loads
    if (f3[2] && st) mis = 1'b1;
    // a request claiming to be both load and store is rejected
    if (ld && st) mis = 1'b1;
    oor = ((addr >> ADDR_WIDTH) != 32'd0);
    return {oor, mis};
  endfunction

  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign w_fault   = calc_fault(req_addr, req_func3, req_is_load, req_is_store);
  assign w_ok_load = r_is_load && !r_is_store && (r_fault == 2'b00);

  // Request FSM: latch on accept, one write/read access, then hold response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_func3     <= '0;
      r_rd        <= '0;
      r_is_load   <= 1'b0;
      r_is_store  <= 1'b0;
      r_fault     <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_mem_we    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_func3    <= req_func3;
            r_rd       <= req_rd;
            r_is_load  <= req_is_load;
            r_is_store <= req_is_store;
            r_fault    <= w_fault;
            r_rsp_data <= '0;
            // write strobe is live for exactly the ACCESS cycle
            r_mem_we   <= req_is_store && (w_fault == 2'b00);
            r_state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_mem_we <= 1'b0;
          if (w_ok_load) begin
            r_state <= S_READ;
          end else begin
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_READ: begin
          // memory output now reflects the address presented in ACCESS
          r_rsp_data  <= mem_load_data;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready      = (r_state == S_IDLE);
  assign mem_en_write   = r_mem_we;
  assign mem_address    = r_addr;
  assign mem_store_data = r_wdata;
  assign mem_func3      = r_func3;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_data       = r_rsp_data;
  assign rsp_rd         = w_ok_load ? r_rd : 5'd0;
  assign rsp_fault      = r_fault;
  assign rsp_badaddr    = (r_fault != 2'b00) ? r_addr : 32'd0;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: behavioural data memory plus a byte-array
// reference model of what each request must return.
module tb_lsu_mem_stage;

  localparam int AW  = 6;
  localparam int MSZ = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_is_load, req_is_store;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_func3;
  logic [4:0]  req_rd;
  logic        mem_en_write;
  logic [31:0] mem_address, mem_store_data, mem_load_data;
  logic [2:0]  mem_func3;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data, rsp_badaddr;
  logic [4:0]  rsp_rd;
  logic [1:0]  rsp_fault;

  always #5 clk = ~clk;

  lsu_mem_stage #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_load(req_is_load), .req_is_store(req_is_store),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_func3(req_func3), .req_rd(req_rd),
    .mem_en_write(mem_en_write), .mem_address(mem_address),
    .mem_store_data(mem_store_data), .mem_func3(mem_func3), .mem_load_data(mem_load_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_fault(rsp_fault), .rsp_badaddr(rsp_badaddr)
  );

  int vectors = 0;
  int miscompares = 0;
  int wr_count = 0;

  logic [7:0] dm [MSZ];   // behavioural data memory seen by the DUT
  logic [7:0] rm [MSZ];   // reference model's view of memory

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic [1:0]  fault;
    logic [31:0] bad;
    int          lat;
    int          wr;
  } rsp_t;

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] f3);
    case (f3)
      3'd0:    return {{24{w[7]}}, w[7:0]};
      3'd1:    return {{16{w[15]}}, w[15:0]};
      3'd4:    return {24'h0, w[7:0]};
      3'd5:    return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] dm_word(input logic [31:0] a);
    int b;
    b = int'(a[AW-1:0]);
    return {dm[(b+3)%MSZ], dm[(b+2)%MSZ], dm[(b+1)%MSZ], dm[b]};
  endfunction

  function automatic logic [31:0] rm_word(input logic [31:0] a);
    int b;
    b = int'(a[AW-1:0]);
    return {rm[(b+3)%MSZ], rm[(b+2)%MSZ], rm[(b+1)%MSZ], rm[b]};
  endfunction

  // synchronous-read data memory with sub-word handling
  always @(posedge clk) begin
    mem_load_data <= ext(dm_word(mem_address), mem_func3);
    if (mem_en_write) begin
      for (int i = 0; i < (1 << mem_func3[1:0]); i++)
        dm[(int'(mem_address[AW-1:0]) + i) % MSZ] <= mem_store_data[8*i +: 8];
    end
  end

  always @(posedge clk) if (mem_en_write) wr_count <= wr_count + 1;

  // Reference: expected response for a request, applied to rm in program order.
  function automatic rsp_t ref_req(input bit ld, input bit st, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [2:0] f3,
                                   input logic [4:0] rd);
    rsp_t r;
    bit   mis, oor;
    int   sz;
    r = '{default: 0};
    mis = (ld && st) || (f3 == 3) || (f3 >= 6) || (st && f3 >= 4);
    if (f3[1:0] == 2'd1 && (addr % 2) != 0) mis = 1;
    if (f3[1:0] == 2'd2 && (addr % 4) != 0) mis = 1;
    oor = (addr >= MSZ);
    r.fault = {oor, mis};
    r.lat = 2;
    if (r.fault != 0) begin
      r.bad = addr;
    end else if (ld && !st) begin
      r.data = ext(rm_word(addr), f3);
      r.rd = rd;
      r.lat = 3;
    end else if (st) begin
      sz = 1 << f3[1:0];
      for (int i = 0; i < sz; i++) rm[(int'(addr) + i) % MSZ] = wdata[8*i +: 8];
      r.wr = 1;
    end
    return r;
  endfunction

  // Drives one request with rsp_ready high and records what came back.
  task automatic issue(input bit ld, input bit st, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] f3,
                       input logic [4:0] rd, output rsp_t obs, output bit to);
    int n;
    int w0;
    obs = '{default: 0};
    to = 0;
    @(negedge clk);
    req_valid = 1; req_is_load = ld; req_is_store = st;
    req_addr = addr; req_wdata = wdata; req_func3 = f3; req_rd = rd;
    rsp_ready = 1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin to = 1; req_valid = 0; return; end
    w0 = wr_count;
    @(posedge clk);
    obs.lat = 1;
    @(negedge clk);
    req_valid = 0;
    while (!rsp_valid && obs.lat < 10) begin
      @(posedge clk); obs.lat++; @(negedge clk);
    end
    if (!rsp_valid) to = 1;
    obs.data = rsp_data; obs.rd = rsp_rd; obs.fault = rsp_fault; obs.bad = rsp_badaddr;
    obs.wr = wr_count - w0;
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    vectors++; if (mem_en_write !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we: got %b expected 0", mem_en_write); end
    vectors++; if (mem_address !== 32'd0) begin miscompares++; $display("FAIL reset_mem_addr: got %h expected 0", mem_address); end
    vectors++; if (rsp_data !== 32'd0) begin miscompares++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
    vectors++; if ({rsp_fault, rsp_rd, rsp_badaddr} !== '0) begin miscompares++; $display("FAIL reset_rsp_misc: got %h expected 0", {rsp_fault, rsp_rd, rsp_badaddr}); end
    rst_n = 1;
  endtask

  task automatic test_store_load();
    rsp_t o, e; bit to;
    e = ref_req(0, 1, 32'h08, 32'hDEADBEEF, 3'd2, 5'd1);
    issue(0, 1, 32'h08, 32'hDEADBEEF, 3'd2, 5'd1, o, to);
    vectors++; if (to) begin miscompares++; $display("FAIL sw_timeout: got timeout expected response"); end
    vectors++; if (o.wr != 1) begin miscompares++; $display("FAIL sw_write_cycles: got %0d expected 1", o.wr); end
    vectors++; if (o.lat != e.lat) begin miscompares++; $display("FAIL sw_latency: got %0d expected %0d", o.lat, e.lat); end
    vectors++; if (o.rd !== 5'd0) begin miscompares++; $display("FAIL sw_rd: got %0d expected 0", o.rd); end
    e = ref_req(1, 0, 32'h08, 32'h0, 3'd2, 5'd7);
    issue(1, 0, 32'h08, 32'h0, 3'd2, 5'd7, o, to);
    vectors++; if (to) begin miscompares++; $display("FAIL lw_timeout: got timeout expected response"); end
    vectors++; if (o.data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lw_data: got %h expected deadbeef", o.data); end
    vectors++; if (o.rd !== 5'd7) begin miscompares++; $display("FAIL lw_rd: got %0d expected 7", o.rd); end
    vectors++; if (o.fault !== 2'b00) begin miscompares++; $display("FAIL lw_fault: got %b expected 00", o.fault); end
    vectors++; if (o.lat != 3) begin miscompares++; $display("FAIL lw_latency: got %0d expected 3", o.lat); end
    vectors++; if (o.wr != 0) begin miscompares++; $display("FAIL lw_write_cycles: got %0d expected 0", o.wr); end
  endtask

  task automatic test_subword();
    rsp_t o, e; bit to;
    logic [2:0]  f3s [3] = '{3'd0, 3'd4, 3'd1};
    logic [31:0] exp [3] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF};
    e = ref_req(0, 1, 32'h10, 32'h000080FF, 3'd2, 5'd0);
    issue(0, 1, 32'h10, 32'h000080FF, 3'd2, 5'd0, o, to);
    for (int i = 0; i < 3; i++) begin
      e = ref_req(1, 0, 32'h10, 32'h0, f3s[i], 5'd5);
      issue(1, 0, 32'h10, 32'h0, f3s[i], 5'd5, o, to);
      vectors++; if (to || o.data !== exp[i]) begin miscompares++; $display("FAIL subword_f3_%0d: got %h expected %h", f3s[i], o.data, exp[i]); end
    end
  endtask

  task automatic test_misaligned();
    rsp_t o, e; bit to;
    e = ref_req(1, 0, 32'h0A, 32'h0, 3'd2, 5'd4);
    issue(1, 0, 32'h0A, 32'h0, 3'd2, 5'd4, o, to);
    vectors++; if (to || o.fault !== 2'b01) begin miscompares++; $display("FAIL mis_lw_fault: got %b expected 01", o.fault); end
    vectors++; if (o.bad !== 32'h0A) begin miscompares++; $display("FAIL mis_lw_badaddr: got %h expected 0000000a", o.bad); end
    vectors++; if (o.rd !== 5'd0 || o.data !== 32'd0) begin miscompares++; $display("FAIL mis_lw_rd_data: got %0d/%h expected 0/0", o.rd, o.data); end
    e = ref_req(0, 1, 32'h05, 32'hCAFE1234, 3'd1, 5'd0);
    issue(0, 1, 32'h05, 32'hCAFE1234, 3'd1, 5'd0, o, to);
    vectors++; if (to || o.fault !== 2'b01) begin miscompares++; $display("FAIL mis_sh_fault: got %b expected 01", o.fault); end
    vectors++; if (o.bad !== 32'h05) begin miscompares++; $display("FAIL mis_sh_badaddr: got %h expected 00000005", o.bad); end
    vectors++; if (o.wr != 0) begin miscompares++; $display("FAIL mis_sh_write: got %0d expected 0", o.wr); end
    e = ref_req(1, 0, 32'h08, 32'h0, 3'd2, 5'd2);
    issue(1, 0, 32'h08, 32'h0, 3'd2, 5'd2, o, to);
    vectors++; if (to || o.data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL mis_followup_lw: got %h expected deadbeef", o.data); end
  endtask

  task automatic test_out_of_range();
    rsp_t o, e; bit to;
    logic [31:0] w0;
    w0 = rm_word(32'h0);
    e = ref_req(0, 1, 32'h40, 32'h55AA55AA, 3'd2, 5'd0);
    issue(0, 1, 32'h40, 32'h55AA55AA, 3'd2, 5'd0, o, to);
    vectors++; if (to || o.fault !== 2'b10) begin miscompares++; $display("FAIL oor_fault: got %b expected 10", o.fault); end
    vectors++; if (o.bad !== 32'h40) begin miscompares++; $display("FAIL oor_badaddr: got %h expected 00000040", o.bad); end
    vectors++; if (o.wr != 0) begin miscompares++; $display("FAIL oor_write: got %0d expected 0", o.wr); end
    e = ref_req(1, 0, 32'h00, 32'h0, 3'd2, 5'd3);
    issue(1, 0, 32'h00, 32'h0, 3'd2, 5'd3, o, to);
    vectors++; if (to || o.data !== w0) begin miscompares++; $display("FAIL oor_word0: got %h expected %h", o.data, w0); end
  endtask

  task automatic test_backpressure();
    rsp_t e, e2, o; bit to;
    logic [31:0] d0; logic [4:0] r0; logic [1:0] f0;
    int n;
    e = ref_req(1, 0, 32'h08, 32'h0, 3'd2, 5'd9);
    @(negedge clk);
    req_valid = 1; req_is_load = 1; req_is_store = 0; req_addr = 32'h08;
    req_wdata = 0; req_func3 = 3'd2; req_rd = 5'd9; rsp_ready = 0;
    @(posedge clk);
    @(negedge clk);
    // a store waits on the request port for the whole stall
    req_is_load = 0; req_is_store = 1; req_addr = 32'h0C; req_wdata = 32'h12345678; req_rd = 5'd3;
    n = 0;
    while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
    vectors++; if (!rsp_valid) begin miscompares++; $display("FAIL bp_timeout: got no response expected one"); end
    d0 = rsp_data; r0 = rsp_rd; f0 = rsp_fault;
    vectors++; if (d0 !== e.data || r0 !== e.rd || f0 !== e.fault) begin miscompares++; $display("FAIL bp_rsp: got %h/%0d/%b expected %h/%0d/%b", d0, r0, f0, e.data, e.rd, e.fault); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++; if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_rd !== r0 || rsp_fault !== f0) begin miscompares++; $display("FAIL bp_hold_%0d: got %b/%h/%0d/%b expected 1/%h/%0d/%b", i, rsp_valid, rsp_data, rsp_rd, rsp_fault, d0, r0, f0); end
      vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_req_ready_%0d: got %b expected 0", i, req_ready); end
    end
    rsp_ready = 1;
    @(negedge clk);
    vectors++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL bp_after_handshake: got valid %b ready %b expected 0 1", rsp_valid, req_ready); end
    e2 = ref_req(0, 1, 32'h0C, 32'h12345678, 3'd2, 5'd3);
    @(negedge clk);
    req_valid = 0;
    vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_pending_accept: got ready %b expected 0", req_ready); end
    n = 0;
    while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
    vectors++; if (!rsp_valid || rsp_fault !== e2.fault) begin miscompares++; $display("FAIL bp_store_rsp: got %b/%b expected 1/%b", rsp_valid, rsp_fault, e2.fault); end
    @(posedge clk);
    e = ref_req(1, 0, 32'h0C, 32'h0, 3'd2, 5'd1);
    issue(1, 0, 32'h0C, 32'h0, 3'd2, 5'd1, o, to);
    vectors++; if (to || o.data !== 32'h12345678) begin miscompares++; $display("FAIL bp_store_data: got %h expected 12345678", o.data); end
  endtask

  task automatic test_reset_mid_load();
    rsp_t o, e; bit to;
    @(negedge clk);
    req_valid = 1; req_is_load = 1; req_is_store = 0; req_addr = 32'h08;
    req_wdata = 0; req_func3 = 3'd2; req_rd = 5'd6; rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    rst_n = 0;
    #1;
    vectors++; if (rsp_valid !== 1'b0 || mem_en_write !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_now: got valid %b we %b ready %b expected 0 0 1", rsp_valid, mem_en_write, req_ready); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_hold_%0d: got valid %b expected 0", i, rsp_valid); end
    end
    rst_n = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_release_%0d: got valid %b ready %b expected 0 1", i, rsp_valid, req_ready); end
    end
    e = ref_req(1, 0, 32'h08, 32'h0, 3'd2, 5'd6);
    issue(1, 0, 32'h08, 32'h0, 3'd2, 5'd6, o, to);
    vectors++; if (to || o.data !== e.data || o.rd !== 5'd6 || o.lat != 3) begin miscompares++; $display("FAIL rst_mid_newload: got %h/%0d/%0d expected %h/6/3", o.data, o.rd, o.lat, e.data); end
  endtask

  task automatic test_random();
    rsp_t o, e; bit to;
    bit ld, st;
    logic [31:0] addr, wd;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [2:0]  legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    int k;
    for (int it = 0; it < 80; it++) begin
      k = $urandom_range(0, 9);
      ld = (k <= 3) || (k == 9);
      st = (k >= 4 && k <= 7) || (k == 9);
      addr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, MSZ - 1));
      if ($urandom_range(0, 1) == 0) addr = addr & ~32'd3;
      f3 = ($urandom_range(0, 3) != 0) ? legal[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      wd = $urandom;
      rd = 5'($urandom_range(1, 31));
      e = ref_req(ld, st, addr, wd, f3, rd);
      issue(ld, st, addr, wd, f3, rd, o, to);
      vectors++; if (to) begin miscompares++; $display("FAIL rnd%0d_timeout: got timeout expected response", it); end
      vectors++; if (o.data !== e.data) begin miscompares++; $display("FAIL rnd%0d_data: got %h expected %h", it, o.data, e.data); end
      vectors++; if (o.rd !== e.rd) begin miscompares++; $display("FAIL rnd%0d_rd: got %0d expected %0d", it, o.rd, e.rd); end
      vectors++; if (o.fault !== e.fault) begin miscompares++; $display("FAIL rnd%0d_fault: got %b expected %b", it, o.fault, e.fault); end
      vectors++; if (o.bad !== e.bad) begin miscompares++; $display("FAIL rnd%0d_badaddr: got %h expected %h", it, o.bad, e.bad); end
      vectors++; if (o.lat != e.lat) begin miscompares++; $display("FAIL rnd%0d_latency: got %0d expected %0d", it, o.lat, e.lat); end
      vectors++; if (o.wr != e.wr) begin miscompares++; $display("FAIL rnd%0d_writes: got %0d expected %0d", it, o.wr, e.wr); end
    end
  endtask

  initial begin
    for (int i = 0; i < MSZ; i++) begin
      dm[i] = 8'($urandom);
      rm[i] = dm[i];
    end
    rst_n = 0;
    req_valid = 0; req_is_load = 0; req_is_store = 0;
    req_addr = 0; req_wdata = 0; req_func3 = 0; req_rd = 0;
    rsp_ready = 1;
    test_reset();
    test_store_load();
    test_subword();
    test_misaligned();
    test_out_of_range();
    test_backpressure();
    test_reset_mid_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
